// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes on both sides. Single-cycle ops
// resolve on the accepting edge; MULT/DIV variants iterate one bit per cycle.
module alu_seq #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [5:0]       functn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             negativeFlag,
    output logic             zeroFlag,
    output logic             carryFlag,
    output logic             overflowFlag,
    output logic             illegalFlag,
    output logic             divzeroFlag,
    output logic [1:0]       state_dbg_o
);

    localparam logic [5:0] F_SLL  = 6'b000000, F_SRL  = 6'b000010, F_SRA  = 6'b000011;
    localparam logic [5:0] F_ADD  = 6'b100000, F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010, F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100, F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110, F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010, F_SLTU = 6'b101011;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    // Handshake: a transfer happens on an edge where valid and ready are both
    // high; out_valid stays high with lo/hi/flags stable until out_ready.
    state_t           state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             accept, start_md, load_res, in_rdy;

    logic [WIDTH-1:0] a_q, b_q, acc_hi_q, acc_lo_q, mcand_q;
    logic [5:0]       fn_q;
    logic [WIDTH-1:0] lo_q, hi_q, lo_d, hi_d;
    logic             neg_q, zero_q, carry_q, ovf_q, ill_q, dz_q;
    logic             carry_d, ovf_d, ill_d, dz_d;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? -x : x;
    endfunction

    function automatic logic is_muldiv(input logic [5:0] fn);
        return fn[5:2] == 4'b0110;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        in_rdy   = 1'b0;
        start_md = 1'b0;
        load_res = 1'b0;
        case (state_q)
            IDLE:    in_rdy = 1'b1;
            DONE:    in_rdy = out_ready;
            default: in_rdy = 1'b0;
        endcase
        accept = in_valid && in_rdy;
        case (state_q)
            BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d  = DONE;
                    load_res = 1'b1;
                end
            end
            default: begin
                if (accept) begin
                    if (is_muldiv(functn)) begin
                        state_d  = BUSY;
                        cnt_d    = SHW'(WIDTH - 1);
                        start_md = 1'b1;
                    end else begin
                        state_d  = DONE;
                        load_res = 1'b1;
                    end
                end else if (state_q == DONE && out_ready) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // One shift-add (multiply) or restore-subtract (divide) step.
    logic [WIDTH:0]     mul_sum, div_sh, div_sub;
    logic               div_ge;
    logic [WIDTH-1:0]   step_hi, step_lo;

    always_comb begin
        mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);
        div_sh  = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_sub = div_sh - {1'b0, mcand_q};
        div_ge  = div_sh >= {1'b0, mcand_q};
        if (fn_q[1]) begin
            step_hi = div_ge ? div_sub[WIDTH-1:0] : div_sh[WIDTH-1:0];
            step_lo = {acc_lo_q[WIDTH-2:0], div_ge};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
    end

    logic [WIDTH:0]     sum_w, dif_w;
    logic [2*WIDTH-1:0] prod;
    logic               md_sgn;

    always_comb begin
        lo_d    = '0;
        hi_d    = '0;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
        ill_d   = 1'b0;
        dz_d    = 1'b0;
        sum_w   = {1'b0, A} + {1'b0, B};
        dif_w   = {1'b0, A} - {1'b0, B};
        md_sgn  = !fn_q[0];
        prod    = {step_hi, step_lo};
        if (state_q == BUSY) begin
            if (!fn_q[1]) begin
                if (md_sgn && (a_q[WIDTH-1] ^ b_q[WIDTH-1]))
                    prod = -prod;
                {hi_d, lo_d} = prod;
            end else if (b_q == '0) begin
                lo_d = '1;
                hi_d = a_q;
                dz_d = 1'b1;
            end else begin
                lo_d  = (md_sgn && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -step_lo : step_lo;
                hi_d  = (md_sgn && a_q[WIDTH-1]) ? -step_hi : step_hi;
                ovf_d = md_sgn && (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
            end
        end else begin
            case (functn)
                F_ADD, F_ADDU: begin
                    lo_d    = sum_w[WIDTH-1:0];
                    carry_d = sum_w[WIDTH];
                    ovf_d   = (functn == F_ADD) && (A[WIDTH-1] == B[WIDTH-1])
                              && (sum_w[WIDTH-1] != A[WIDTH-1]);
                end
                F_SUB, F_SUBU: begin
                    lo_d    = dif_w[WIDTH-1:0];
                    carry_d = dif_w[WIDTH];
                    ovf_d   = (functn == F_SUB) && (A[WIDTH-1] != B[WIDTH-1])
                              && (dif_w[WIDTH-1] != A[WIDTH-1]);
                end
                F_AND:  lo_d = A & B;
                F_OR:   lo_d = A | B;
                F_XOR:  lo_d = A ^ B;
                F_NOR:  lo_d = ~(A | B);
                F_SLT:  lo_d = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
                F_SLTU: lo_d = {{(WIDTH-1){1'b0}}, A < B};
                F_SLL:  lo_d = A << B[SHW-1:0];
                F_SRL:  lo_d = A >> B[SHW-1:0];
                F_SRA:  lo_d = $unsigned($signed(A) >>> B[SHW-1:0]);
                default: ill_d = 1'b1;
            endcase
        end
    end

    // Divide loads the dividend magnitude into acc_lo; multiply loads the multiplier.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q      <= '0;
            b_q      <= '0;
            fn_q     <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            mcand_q  <= '0;
        end else if (start_md) begin
            a_q      <= A;
            b_q      <= B;
            fn_q     <= functn;
            acc_hi_q <= '0;
            acc_lo_q <= functn[1] ? mag(A, !functn[0]) : mag(B, !functn[0]);
            mcand_q  <= functn[1] ? mag(B, !functn[0]) : mag(A, !functn[0]);
        end else if (state_q == BUSY) begin
            acc_hi_q <= step_hi;
            acc_lo_q <= step_lo;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lo_q    <= '0;
            hi_q    <= '0;
            neg_q   <= 1'b0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            ill_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else if (load_res) begin
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            neg_q   <= lo_d[WIDTH-1];
            zero_q  <= (lo_d == '0);
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            ill_q   <= ill_d;
            dz_q    <= dz_d;
        end
    end

    assign in_ready     = in_rdy;
    assign out_valid    = (state_q == DONE);
    assign lo           = lo_q;
    assign hi           = hi_q;
    assign negativeFlag = neg_q;
    assign zeroFlag     = zero_q;
    assign carryFlag    = carry_q;
    assign overflowFlag = ovf_q;
    assign illegalFlag  = ill_q;
    assign divzeroFlag  = dz_q;
    assign state_dbg_o  = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: handshake latency, results, flags, backpressure,
// back-to-back issue and asynchronous reset during a divide.
module tb_alu_seq;
    localparam int W = 32;

    logic         clk, reset_n, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] A, B, lo, hi;
    logic [5:0]   functn;
    logic         negativeFlag, zeroFlag, carryFlag, overflowFlag, illegalFlag, divzeroFlag;
    logic [1:0]   state_dbg;
    logic [5:0]   flags;

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .functn(functn), .out_valid(out_valid), .out_ready(out_ready),
        .lo(lo), .hi(hi), .negativeFlag(negativeFlag), .zeroFlag(zeroFlag),
        .carryFlag(carryFlag), .overflowFlag(overflowFlag), .illegalFlag(illegalFlag),
        .divzeroFlag(divzeroFlag), .state_dbg_o(state_dbg)
    );

    // flags packed as {negative, zero, carry, overflow, illegal, divzero}
    assign flags = {negativeFlag, zeroFlag, carryFlag, overflowFlag, illegalFlag, divzeroFlag};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op from a negedge, count edges until out_valid, end on a negedge.
    task automatic do_op(input string tag, input logic [5:0] fn, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int exp_lat, input bit noise);
        int edges;
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        functn = fn; A = a; B = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        edges = 1;
        while (!out_valid && edges < 100) begin
            if (noise) begin
                in_valid = 1'b1;
                A = $urandom; B = $urandom;
                functn = 6'($urandom_range(0, 63));
            end
            @(posedge clk); #1;
            edges++;
        end
        in_valid = 1'b0;
        chk({tag, "_latency"}, 64'(edges), 64'(exp_lat));
        @(negedge clk);
    endtask

    task automatic chk_res(input string tag, input logic [W-1:0] e_lo, input logic [W-1:0] e_hi,
                           input logic [5:0] e_flags);
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_lo"}, 64'(lo), 64'(e_lo));
        chk({tag, "_hi"}, 64'(hi), 64'(e_hi));
        chk({tag, "_flags"}, 64'(flags), 64'(e_flags));
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_drained"}, 64'(out_valid), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; functn = '0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_lo_hi", {lo, hi}, 64'd0);
        chk("rst_flags", 64'(flags), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        do_op("add", 6'b100000, 32'h7FFFFFFF, 32'h1, 1, 0);
        chk_res("add", 32'h80000000, 32'h0, 6'b100100);
        consume("add");
        do_op("addu", 6'b100001, 32'h7FFFFFFF, 32'h1, 1, 0);
        chk_res("addu", 32'h80000000, 32'h0, 6'b100000);
        consume("addu");
        do_op("add_wrap", 6'b100000, 32'hFFFFFFFF, 32'h1, 1, 0);
        chk_res("add_wrap", 32'h0, 32'h0, 6'b011000);
        consume("add_wrap");
        do_op("subu", 6'b100011, 32'd3, 32'd5, 1, 0);
        chk_res("subu", 32'hFFFFFFFE, 32'h0, 6'b101000);
        consume("subu");
        do_op("sub_ovf", 6'b100010, 32'h80000000, 32'h1, 1, 0);
        chk_res("sub_ovf", 32'h7FFFFFFF, 32'h0, 6'b000100);
        consume("sub_ovf");
        do_op("slt", 6'b101010, 32'hFFFFFFFF, 32'h1, 1, 0);
        chk_res("slt", 32'h1, 32'h0, 6'b000000);
        consume("slt");
        do_op("sltu", 6'b101011, 32'hFFFFFFFF, 32'h1, 1, 0);
        chk_res("sltu", 32'h0, 32'h0, 6'b010000);
        consume("sltu");
        do_op("sll", 6'b000000, 32'h1, 32'd31, 1, 0);
        chk_res("sll", 32'h80000000, 32'h0, 6'b100000);
        consume("sll");
        do_op("srl", 6'b000010, 32'h80000000, 32'h3F, 1, 0);
        chk_res("srl", 32'h1, 32'h0, 6'b000000);
        consume("srl");
        do_op("nor", 6'b100111, 32'h0, 32'h0, 1, 0);
        chk_res("nor", 32'hFFFFFFFF, 32'h0, 6'b100000);
        consume("nor");

        do_op("mult", 6'b011000, 32'hFFFFFFFE, 32'd3, W + 1, 0);
        chk_res("mult", 32'hFFFFFFFA, 32'hFFFFFFFF, 6'b100000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            chk("hold_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
        end
        consume("mult");
        do_op("multu", 6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, W + 1, 0);
        chk_res("multu", 32'h00000001, 32'hFFFFFFFE, 6'b000000);
        consume("multu");

        do_op("div", 6'b011010, 32'hFFFFFFF9, 32'd2, W + 1, 1);
        chk_res("div", 32'hFFFFFFFD, 32'hFFFFFFFF, 6'b100000);
        consume("div");
        do_op("divu_z", 6'b011011, 32'd9, 32'd0, W + 1, 0);
        chk_res("divu_z", 32'hFFFFFFFF, 32'd9, 6'b100001);
        consume("divu_z");
        do_op("div_ovf", 6'b011010, 32'h80000000, 32'hFFFFFFFF, W + 1, 0);
        chk_res("div_ovf", 32'h80000000, 32'h0, 6'b100100);
        consume("div_ovf");

        // Back-to-back: SRA then AND with out_ready held high.
        chk("b2b_in_ready", 64'(in_ready), 64'd1);
        functn = 6'b000011; A = 32'h80000000; B = 32'd4;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        functn = 6'b100100; A = 32'hF0F0F0F0; B = 32'hFF00FF00;
        @(negedge clk);
        chk("b2b_sra_valid", 64'(out_valid), 64'd1);
        chk("b2b_sra_lo", 64'(lo), 64'hF8000000);
        chk("b2b_sra_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_and_valid", 64'(out_valid), 64'd1);
        chk("b2b_and_lo", 64'(lo), 64'hF000F000);
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("b2b_idle", 64'(out_valid), 64'd0);
        @(negedge clk);

        // Asynchronous reset part-way through a divide.
        functn = 6'b011011; A = 32'd100; B = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_lo_hi", {lo, hi}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("arst_no_stray", 64'(out_valid), 64'd0);
        do_op("addu_post", 6'b100001, 32'd5, 32'd6, 1, 0);
        chk_res("addu_post", 32'd11, 32'h0, 6'b000000);
        consume("addu_post");

        do_op("illegal", 6'b111111, 32'h12345678, 32'h9ABCDEF0, 1, 0);
        chk_res("illegal", 32'h0, 32'h0, 6'b010010);
        consume("illegal");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
